// File: rtl/d3s_frev_ts_gen.sv
// Revolution-marker timestamp generator: detects phase wraps in the four-lane phase stream,
// timestamps them against WR time and queues them in a small FWFT FIFO with valid/ready output.
module d3s_frev_ts_gen #(
    parameter int g_fifo_log2    = 2,
    parameter int g_ns_per_cycle = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [15:0] decim_i,
    input  logic [55:0] phase_i,
    input  logic        phase_valid_i,
    input  logic        tm_time_valid_i,
    input  logic [31:0] tm_tai_i,
    input  logic [27:0] tm_cycles_i,
    output logic [31:0] frev_ts_tai_o,
    output logic [31:0] frev_ts_nsec_o,
    output logic        frev_ts_valid_o,
    input  logic        frev_ts_ready_i,
    output logic [15:0] dropped_cnt_o
);

    localparam int          c_depth   = 1 << g_fifo_log2;
    localparam logic [31:0] c_ns      = 32'(g_ns_per_cycle);
    localparam logic [31:0] c_lane_ns = 32'(g_ns_per_cycle / 4);

    // Only the lane MSBs matter for wrap detection, so only those are kept.
    logic        s1_pv, s1_en, s1_tv;
    logic [3:0]  s1_msb;
    logic [31:0] s1_tai;
    logic [27:0] s1_cycles;
    logic        prev_msb, prev_ok;

    logic        phase_unused;
    assign phase_unused = ^phase_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_pv     <= 1'b0;
            s1_en     <= 1'b0;
            s1_tv     <= 1'b0;
            s1_msb    <= '0;
            s1_tai    <= '0;
            s1_cycles <= '0;
        end else begin
            s1_pv     <= phase_valid_i;
            s1_en     <= enable_i;
            s1_tv     <= tm_time_valid_i;
            s1_msb    <= {phase_i[55], phase_i[41], phase_i[27], phase_i[13]};
            s1_tai    <= tm_tai_i;
            s1_cycles <= tm_cycles_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_msb <= 1'b0;
            prev_ok  <= 1'b0;
        end else begin
            if (s1_pv) begin
                prev_msb <= s1_msb[3];
                prev_ok  <= 1'b1;
            end
            if (!enable_i) prev_ok <= 1'b0;
        end
    end

    logic [3:0]  wrap;
    logic        det, accept, emit;
    logic [1:0]  det_lane;
    logic [15:0] dc;

    assign wrap[0] = prev_ok && prev_msb && !s1_msb[0];
    assign wrap[1] = s1_msb[0] && !s1_msb[1];
    assign wrap[2] = s1_msb[1] && !s1_msb[2];
    assign wrap[3] = s1_msb[2] && !s1_msb[3];

    always_comb begin
        det_lane = 2'd0;
        if      (wrap[0]) det_lane = 2'd0;
        else if (wrap[1]) det_lane = 2'd1;
        else if (wrap[2]) det_lane = 2'd2;
        else if (wrap[3]) det_lane = 2'd3;
    end

    assign det    = s1_pv && s1_en && (|wrap);
    assign accept = det && s1_tv;
    assign emit   = accept && (dc == 16'd0);

    // Decimation down-counter: emit on terminal count zero, then reload.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) dc <= '0;
        else if (accept)        dc <= (dc == 16'd0) ? decim_i : dc - 16'd1;
    end

    logic        s2_emit, s3_push;
    logic [1:0]  s2_lane;
    logic [31:0] s2_tai, s3_tai, s3_nsec;
    logic [27:0] s2_cycles;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_emit   <= 1'b0;
            s2_lane   <= '0;
            s2_tai    <= '0;
            s2_cycles <= '0;
            s3_push   <= 1'b0;
            s3_tai    <= '0;
            s3_nsec   <= '0;
        end else begin
            s2_emit   <= emit;
            s2_lane   <= det_lane;
            s2_tai    <= s1_tai;
            s2_cycles <= s1_cycles;
            s3_push   <= s2_emit;
            s3_tai    <= s2_tai;
            s3_nsec   <= ({4'd0, s2_cycles} * c_ns) + ({30'd0, s2_lane} * c_lane_ns);
        end
    end

    logic [31:0]          mem_tai  [c_depth];
    logic [31:0]          mem_nsec [c_depth];
    logic [g_fifo_log2:0] wr_ptr, rd_ptr;
    logic                 empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[g_fifo_log2] != rd_ptr[g_fifo_log2]) &&
                     (wr_ptr[g_fifo_log2-1:0] == rd_ptr[g_fifo_log2-1:0]);
    assign pop     = !empty && frev_ts_ready_i;
    assign push_ok = s3_push && (!full || pop);
    assign drop    = s3_push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_tai[wr_ptr[g_fifo_log2-1:0]]  <= s3_tai;
            mem_nsec[wr_ptr[g_fifo_log2-1:0]] <= s3_nsec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            dropped_cnt_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop && dropped_cnt_o != 16'hFFFF) dropped_cnt_o <= dropped_cnt_o + 16'd1;
        end
    end

    // Gate the head entry so outputs read zero while the FIFO is empty.
    assign frev_ts_valid_o = !empty;
    assign frev_ts_tai_o   = empty ? 32'd0 : mem_tai[rd_ptr[g_fifo_log2-1:0]];
    assign frev_ts_nsec_o  = empty ? 32'd0 : mem_nsec[rd_ptr[g_fifo_log2-1:0]];

endmodule

// File: tb/tb_d3s_frev_ts_gen.sv
// Scoreboard bench for d3s_frev_ts_gen: directed wrap words push expected timestamps,
// a negedge monitor pops and compares on every output handshake.
module tb_d3s_frev_ts_gen;

    logic        clk = 1'b0;
    logic        rst, enable, pv, tv, ready;
    logic [15:0] decim;
    logic [55:0] phase;
    logic [31:0] tai_in;
    logic [27:0] cyc_in;
    logic [31:0] ts_tai, ts_nsec;
    logic        ts_valid;
    logic [15:0] dropped;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int h0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    always #4 clk = ~clk;

    d3s_frev_ts_gen #(.g_fifo_log2(2), .g_ns_per_cycle(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .decim_i(decim),
        .phase_i(phase), .phase_valid_i(pv), .tm_time_valid_i(tv),
        .tm_tai_i(tai_in), .tm_cycles_i(cyc_in),
        .frev_ts_tai_o(ts_tai), .frev_ts_nsec_o(ts_nsec),
        .frev_ts_valid_o(ts_valid), .frev_ts_ready_i(ready),
        .dropped_cnt_o(dropped)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ts_valid && ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ts: got tai=%0d nsec=%0d, expected none", ts_tai, ts_nsec);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("ts_tai", {32'd0, ts_tai}, {32'd0, mon_exp[63:32]});
                chk("ts_nsec", {32'd0, ts_nsec}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        pv = 1'b0;
        tick(n);
    endtask

    task automatic word(input logic [13:0] l0, input logic [13:0] l1, input logic [13:0] l2,
                        input logic [13:0] l3, input logic [31:0] t, input logic [27:0] c,
                        input bit emit, input logic [31:0] exp_nsec);
        phase  = {l3, l2, l1, l0};
        pv     = 1'b1;
        tai_in = t;
        cyc_in = c;
        if (emit) sb_q.push_back({t, exp_nsec});
        tick(1);
        pv = 1'b0;
    endtask

    // All-high word, then a word that first goes low at 'lane'.
    task automatic send_wrap(input int lane, input logic [31:0] t, input logic [27:0] c, input bit emit);
        logic [13:0] l[4];
        for (int k = 0; k < 4; k++) l[k] = (k < lane) ? 14'h3000 : 14'h0010;
        word(14'h3000, 14'h3000, 14'h3000, 14'h3000, t, c - 28'd1, 1'b0, 32'd0);
        word(l[0], l[1], l[2], l[3], t, c, emit, 32'(c) * 32'd8 + 32'(lane) * 32'd2);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb_q.size() == 0 && !ts_valid) break;
            tick(1);
        end
        chk("drain_done", {63'd0, (sb_q.size() == 0 && !ts_valid)}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; pv = 1'b0; tv = 1'b1; ready = 1'b1;
        decim = 16'd0; phase = '0; tai_in = '0; cyc_in = '0;
        tick(3);
        chk("rst_valid", {63'd0, ts_valid}, 64'd0);
        chk("rst_tai", {32'd0, ts_tai}, 64'd0);
        chk("rst_nsec", {32'd0, ts_nsec}, 64'd0);
        chk("rst_dropped", {48'd0, dropped}, 64'd0);
        rst = 1'b0;
        tick(2);

        // ramp crossing at lane 2, latency and single-cycle valid
        word(14'h3A00, 14'h3B00, 14'h3C00, 14'h3D00, 32'd5, 28'd999, 1'b0, 32'd0);
        word(14'h3E00, 14'h3F00, 14'h0000, 14'h0100, 32'd5, 28'd1000, 1'b1, 32'd8004);
        tick(2);
        chk("lat_n2_valid", {63'd0, ts_valid}, 64'd0);
        tick(1);
        chk("lat_n3_valid", {63'd0, ts_valid}, 64'd1);
        tick(1);
        chk("lat_n4_valid", {63'd0, ts_valid}, 64'd0);

        // lane-0 wrap at the last cycle of a second
        idle(2);
        word(14'h3FF0, 14'h3FF0, 14'h3FF0, 14'h3FF0, 32'd7, 28'd124999998, 1'b0, 32'd0);
        word(14'h0010, 14'h0010, 14'h0010, 14'h0010, 32'd7, 28'd124999999, 1'b1, 32'd999999992);
        idle(6);

        // lane-0 wrap on first word after reset must be ignored
        word(14'h3FF0, 14'h3FF0, 14'h3FF0, 14'h3FF0, 32'd8, 28'd10, 1'b0, 32'd0);
        idle(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        word(14'h0010, 14'h0010, 14'h0010, 14'h0010, 32'd8, 28'd20, 1'b0, 32'd0);
        idle(6);
        chk("first_after_rst_valid", {63'd0, ts_valid}, 64'd0);

        // decimation by 3: wraps 1, 4, 7 emit
        decim = 16'd2;
        h0 = hs_cnt;
        for (int i = 0; i < 9; i++) begin
            send_wrap(i % 4, 32'd10, 28'(100 * (i + 1) + 50), (i % 3) == 0);
            idle(18);
        end
        idle(4);
        chk("decim_count", 64'(hs_cnt - h0), 64'd3);

        // backpressure: 6 wraps into a 4-deep FIFO
        decim = 16'd0;
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_wrap(1, 32'd20, 28'(2000 + 10 * i), i < 4);
            idle(1);
        end
        idle(6);
        chk("bp_dropped", {48'd0, dropped}, 64'd2);
        chk("bp_valid", {63'd0, ts_valid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_tai", {32'd0, ts_tai}, {32'd0, sb_q[0][63:32]});
            chk("bp_hold_nsec", {32'd0, ts_nsec}, {32'd0, sb_q[0][31:0]});
            tick(1);
        end
        h0 = hs_cnt;
        ready = 1'b1;
        wait_drain(20);
        chk("bp_handshakes", 64'(hs_cnt - h0), 64'd4);

        // time-invalid wrap leaves dc alone; enable toggle rearms
        decim = 16'd2;
        h0 = hs_cnt;
        send_wrap(2, 32'd30, 28'd3000, 1'b1); idle(3);
        tv = 1'b0;
        send_wrap(2, 32'd30, 28'd3100, 1'b0); idle(3);
        tv = 1'b1;
        send_wrap(2, 32'd30, 28'd3200, 1'b0); idle(3);
        send_wrap(2, 32'd30, 28'd3300, 1'b0); idle(3);
        send_wrap(2, 32'd30, 28'd3400, 1'b1); idle(3);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        send_wrap(3, 32'd30, 28'd3500, 1'b1);
        idle(6);
        chk("tv_en_handshakes", 64'(hs_cnt - h0), 64'd3);
        wait_drain(20);

        // reset with queued entries and one in flight
        decim = 16'd0;
        ready = 1'b0;
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_wrap(0, 32'd40, 28'(4000 + 10 * i), 1'b0);
            idle(1);
        end
        idle(6);
        chk("pre_rst_valid", {63'd0, ts_valid}, 64'd1);
        chk("pre_rst_dropped", {48'd0, dropped}, 64'd2);
        send_wrap(1, 32'd40, 28'd4100, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_valid", {63'd0, ts_valid}, 64'd0);
        chk("post_rst_dropped", {48'd0, dropped}, 64'd0);
        rst = 1'b0;
        ready = 1'b1;
        idle(10);
        chk("post_rst_no_stale", {63'd0, ts_valid}, 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
